instr_decode_stage: RTL
=======================

# instr_decode_stage

Registered, parametrised instruction decode stage between instruction fetch and the ALU/register-file stage. Splits each instruction word into a 5-bit operation mnemonic, register index and extended immediate, with valid/ready handshakes on both sides. A 2-entry skid buffer gives full throughput under backpressure. The stage latches a halted state on HALT or on an illegal encoding and counts retired decodes.

## Interface
- IW, 9: instruction width; must be ≥ 9.
- DW, 8: datapath width of `imm_o`; must be ≥ IW-3.
- CW, 16: width of the decode counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid_i  in  1  fetch presents `in_instr_i`.
- in_ready_o  out  1  stage accepts a word this cycle.
- in_instr_i  in  IW  instruction word.
- out_valid_o  out  1  decoded word valid.
- out_ready_i  in  1  downstream accepts.
- op_o  out  5  op_mne code.
- reg_o  out  IW-6  register field (typeI only, else 0).
- imm_o  out  DW  extended immediate.
- illegal_o  out  1  the word carried by `op_o` was an illegal encoding.
- halted_o  out  1  stage halted.
- resume_i  in  1  single-cycle pulse that clears the halted state.
- dec_count_o  out  CW  number of completed output transfers.

## Operation
- Type is `instr[IW-1:IW-2]`.
- typeI (00):
  - Opcode is `instr[IW-3:IW-6]`; reg = `instr[IW-7:0]`.
  - ADD→ADD, MOVER→MOVER, MOVEA→MOVEA, RXOR→RXOR, LUT→LUT, XOR→XOR, AND→AND, LOAD→LOAD, STORE→STORE, HALT→HALT.
  - Opcodes 1010–1111 → op=HALT, illegal=1.
  - imm = 0.
- typeII (01):
  - Sub-op is `instr[IW-3:IW-4]`: 00→BEQ, 01→BLT.
  - Sub-ops 10/11 → op=HALT, illegal=1.
  - imm = `instr[IW-5:0]`, sign-extended to DW.
- typeIII (10):
  - Sub-op 00→ANDI, 01→ADDI, 10→SUB, 11→JUMP.
  - imm = `instr[IW-5:0]`: sign-extended for JUMP, zero-extended otherwise.
- typeIV (11):
  - `instr[IW-3]` selects 0→LSR, 1→RSR.
  - imm = `instr[IW-4:0]`, zero-extended.
- Input acceptance: a word is accepted when `in_valid_i && in_ready_o`.
- `in_ready_o` = !halted && !skid_full; it is a registered signal, not combinational from `out_ready_i`.
- Halting:
  - Accepting a word that decodes to HALT (legal or illegal) sets halted at the next edge.
  - The HALT word itself is still delivered downstream.
- Resume: `resume_i` while halted clears halted at the next edge; `resume_i` while not halted is ignored.
- Counter: `dec_count_o` increments on each `out_valid_o && out_ready_i` and wraps modulo 2^CW.

## Timing
- Latency: 1 cycle from acceptance to `out_valid_o` when the output register is empty.
- Reset values: out_valid_o=0, in_ready_o=1, op_o=LSR (0), reg_o=0, imm_o=0, illegal_o=0, halted_o=0, dec_count_o=0.
- Output stability: outputs are stable while `out_valid_o && !out_ready_i`.
- Skid buffer:
  - Output register full, downstream stalled and a word accepted → the word goes to the skid entry and `in_ready_o` drops the next cycle.
  - On the next output transfer, the skid entry moves to the output register and `in_ready_o` rises the cycle after.
- Throughput: one word per cycle when `out_ready_i` is held at 1.
- Simultaneous events:
  - Output transfer and input acceptance in the same cycle: the output register reloads with the new word and the counter increments.
  - HALT accepted and `resume_i` in the same cycle: halt wins.
- Halted state: words in flight (output and skid) still drain; `in_ready_o` stays 0 until resume.
- Reset mid-operation clears both buffer entries immediately; in-flight words are discarded.

## Structure
- Type codes, opcodes, sub-op codes and the `op_mne` enum belong in the shared `definitions` package.
- New package entries:
  - field-slice helper functions parametrised on IW;
  - `decode_t` struct {op, reg, imm, illegal}.
- One sub-module, `instr_field_decode`, combinational: instruction → `decode_t`.
- The top level holds the skid buffer, halt latch and counter.

## Test plan
- Reset, then stream 00_0000_011, 01_00_11111, 10_01_00101, 11_1_000011 with out_ready=1 → one output per cycle:
  - ADD, reg=3;
  - BEQ, imm=8'hFF;
  - ADDI, imm=5;
  - RSR, imm=3;
  - dec_count=4.
- Hold out_ready=0 for 3 cycles during a continuous stream → exactly 2 words buffered, in_ready=0 from the cycle after the second acceptance, then no loss or duplication on release.
- Accept 00_1001_000 → op=HALT, illegal=0, halted=1 the next cycle, in_ready=0; pulse resume → in_ready=1 the following cycle.
- Accept 00_1100_000 → op=HALT, illegal=1, halted=1.
- Preload dec_count to 2^CW-1 by streaming with CW=4 → the 16th transfer wraps it to 0.
- Assert rst_n=0 while both entries are full → out_valid=0 and in_ready=1 immediately; no stale word after reset release.

Source files
------------

// File: rtl/definitions_pkg.sv
// rtl/definitions_pkg.sv - shared instruction encodings, op mnemonics and decode helpers
package definitions;

  localparam int MAX_IW    = 32;
  localparam int REG_MAX_W = MAX_IW - 6;
  localparam int IMM_MAX_W = 32;

  localparam logic [1:0] TYPE_I   = 2'b00;
  localparam logic [1:0] TYPE_II  = 2'b01;
  localparam logic [1:0] TYPE_III = 2'b10;
  localparam logic [1:0] TYPE_IV  = 2'b11;

  localparam logic [3:0] OPC_ADD   = 4'd0;
  localparam logic [3:0] OPC_MOVER = 4'd1;
  localparam logic [3:0] OPC_MOVEA = 4'd2;
  localparam logic [3:0] OPC_RXOR  = 4'd3;
  localparam logic [3:0] OPC_LUT   = 4'd4;
  localparam logic [3:0] OPC_XOR   = 4'd5;
  localparam logic [3:0] OPC_AND   = 4'd6;
  localparam logic [3:0] OPC_LOAD  = 4'd7;
  localparam logic [3:0] OPC_STORE = 4'd8;
  localparam logic [3:0] OPC_HALT  = 4'd9;

  localparam logic [1:0] SUB_BEQ  = 2'b00;
  localparam logic [1:0] SUB_BLT  = 2'b01;
  localparam logic [1:0] SUB_ANDI = 2'b00;
  localparam logic [1:0] SUB_ADDI = 2'b01;
  localparam logic [1:0] SUB_SUB  = 2'b10;
  localparam logic [1:0] SUB_JUMP = 2'b11;

  typedef enum logic [4:0] {
    OP_LSR, OP_RSR, OP_ADD, OP_MOVER, OP_MOVEA, OP_RXOR, OP_LUT, OP_XOR, OP_AND,
    OP_LOAD, OP_STORE, OP_HALT, OP_BEQ, OP_BLT, OP_ANDI, OP_ADDI, OP_SUB, OP_JUMP
  } op_mne_t;

  // Fields sized for the widest supported instruction; users slice to their own widths.
  typedef struct packed {
    op_mne_t                op;
    logic [REG_MAX_W-1:0]   reg_f;
    logic [IMM_MAX_W-1:0]   imm;
    logic                   illegal;
  } decode_t;

  function automatic logic [1:0] f_type(input logic [MAX_IW-1:0] instr, input int iw);
    return instr[iw-1 -: 2];
  endfunction

  function automatic logic [3:0] f_opcode(input logic [MAX_IW-1:0] instr, input int iw);
    return instr[iw-3 -: 4];
  endfunction

  function automatic logic [1:0] f_subop(input logic [MAX_IW-1:0] instr, input int iw);
    return instr[iw-3 -: 2];
  endfunction

  function automatic logic f_dir(input logic [MAX_IW-1:0] instr, input int iw);
    return instr[iw-3];
  endfunction

endpackage

// File: rtl/instr_decode_stage_field_decode.sv
// rtl/instr_decode_stage_field_decode.sv - combinational instruction word to decode_t
module instr_field_decode
  import definitions::*;
#(
  parameter int IW = 9,
  parameter int DW = 8
) (
  input  logic [IW-1:0] instr,
  output decode_t       dec
);

  logic [MAX_IW-1:0] instr_ext;
  assign instr_ext = MAX_IW'(instr);

  always_comb begin
    dec = '0;
    case (f_type(instr_ext, IW))
      TYPE_I: begin
        dec.reg_f = REG_MAX_W'(instr[IW-7:0]);
        case (f_opcode(instr_ext, IW))
          OPC_ADD:   dec.op = OP_ADD;
          OPC_MOVER: dec.op = OP_MOVER;
          OPC_MOVEA: dec.op = OP_MOVEA;
          OPC_RXOR:  dec.op = OP_RXOR;
          OPC_LUT:   dec.op = OP_LUT;
          OPC_XOR:   dec.op = OP_XOR;
          OPC_AND:   dec.op = OP_AND;
          OPC_LOAD:  dec.op = OP_LOAD;
          OPC_STORE: dec.op = OP_STORE;
          OPC_HALT:  dec.op = OP_HALT;
          default: begin
            dec.op      = OP_HALT;
            dec.illegal = 1'b1;
          end
        endcase
      end
      TYPE_II: begin
        dec.imm = IMM_MAX_W'($signed(instr[IW-5:0]));
        case (f_subop(instr_ext, IW))
          SUB_BEQ: dec.op = OP_BEQ;
          SUB_BLT: dec.op = OP_BLT;
          default: begin
            dec.op      = OP_HALT;
            dec.illegal = 1'b1;
          end
        endcase
      end
      TYPE_III: begin
        dec.imm = IMM_MAX_W'(instr[IW-5:0]);
        case (f_subop(instr_ext, IW))
          SUB_ANDI: dec.op = OP_ANDI;
          SUB_ADDI: dec.op = OP_ADDI;
          SUB_SUB:  dec.op = OP_SUB;
          default: begin
            dec.op  = OP_JUMP;
            dec.imm = IMM_MAX_W'($signed(instr[IW-5:0]));
          end
        endcase
      end
      default: begin
        dec.op  = f_dir(instr_ext, IW) ? OP_RSR : OP_LSR;
        dec.imm = IMM_MAX_W'(instr[IW-4:0]);
      end
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - registered decode stage with 2-entry skid buffer, halt latch and counter
module instr_decode_stage
  import definitions::*;
#(
  parameter int IW = 9,
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [IW-1:0] in_instr_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output op_mne_t       op_o,
  output logic [IW-7:0] reg_o,
  output logic [DW-1:0] imm_o,
  output logic          illegal_o,
  output logic          halted_o,
  input  logic          resume_i,
  output logic [CW-1:0] dec_count_o
);

  typedef struct packed {
    op_mne_t       op;
    logic [IW-7:0] rf;
    logic [DW-1:0] imm;
    logic          illegal;
  } entry_t;

  function automatic logic [IW-7:0] reg_of(input decode_t d);
    return d.reg_f[IW-7:0];
  endfunction

  function automatic logic [DW-1:0] imm_of(input decode_t d);
    return d.imm[DW-1:0];
  endfunction

  decode_t       dec;
  entry_t        entry;
  entry_t        out_q, out_d, skid_q, skid_d;
  logic          out_valid_q, out_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          halted_q, halted_d;
  logic          in_ready_q, in_ready_d;
  logic [CW-1:0] count_q;
  logic          accept, xfer;

  instr_field_decode #(.IW(IW), .DW(DW)) u_field_decode (
    .instr (in_instr_i),
    .dec   (dec)
  );

  assign entry  = '{op: dec.op, rf: reg_of(dec), imm: imm_of(dec), illegal: dec.illegal};
  assign accept = in_valid_i && in_ready_q;
  assign xfer   = out_valid_q && out_ready_i;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    halted_d     = halted_q;
    // The skid entry is only ever loaded while in_ready is high, so it never competes with accept.
    if (!out_valid_q || out_ready_i) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = entry;
      skid_valid_d = 1'b1;
    end
    if (accept && dec.op == OP_HALT) begin
      halted_d = 1'b1;
    end else if (resume_i) begin
      halted_d = 1'b0;
    end
    in_ready_d = !halted_d && !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      in_ready_q   <= 1'b1;
      count_q      <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      halted_q     <= halted_d;
      in_ready_q   <= in_ready_d;
      if (xfer) begin
        count_q <= count_q + CW'(1);
      end
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign op_o        = out_q.op;
  assign reg_o       = out_q.rf;
  assign imm_o       = out_q.imm;
  assign illegal_o   = out_q.illegal;
  assign halted_o    = halted_q;
  assign dec_count_o = count_q;

endmodule
